y86_mem_arbiter: RTL

- Shares one single-ported 64-bit data memory between two requesters: the instruction-fetch port (I) and the data/stack port (D).
- The D port serves rmmovq, mrmovq, call, ret, pushq and popq.
- Performs round-robin arbitration, one access per cycle, a registered one-cycle response, bounds checking with an error flag, and a saturating conflict counter.
- Sits between the fetch/memory stages and the memory array, which is owned by this block.

---
 rtl/y86_mem_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/y86_mem_arbiter.sv
// Shared 64-bit data memory for the Y86 fetch (I) and data/stack (D) ports.
// Round-robin arbitration, one access per cycle, registered responses, bounds checking.
module y86_mem_arbiter #(
    parameter int DEPTH         = 1024,
    parameter bit INIT_IDENTITY = 1'b1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [63:0]      i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [63:0]      i_rdata,
    output logic             i_err,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [63:0]      d_addr,
    input  logic [63:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [63:0]      d_rdata,
    output logic             d_err,
    output logic [CNT_W-1:0] conflict_cnt
);
    localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0]     DEPTH64 = 64'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        WIN_I = 1'b0,
        WIN_D = 1'b1
    } win_e;

    win_e        last_win;
    logic        both_req;
    logic        gnt_i;
    logic        gnt_d;
    logic        in_range;
    logic        wr_en;
    logic [63:0] acc_addr;
    logic [63:0] rd_word;
    logic [AW-1:0] idx;
    logic [63:0] mem_rd [DEPTH];

    // A request is accepted in the cycle gnt is high: req/addr/we/wdata are
    // sampled at the closing edge, and the response appears for one cycle after it.
    always_comb begin
        both_req = i_req && d_req;
        gnt_i    = 1'b0;
        gnt_d    = 1'b0;
        if (!rst) begin
            if (both_req) begin
                gnt_i = (last_win == WIN_D);
                gnt_d = (last_win == WIN_I);
            end else begin
                gnt_i = i_req;
                gnt_d = d_req;
            end
        end
        acc_addr = gnt_d ? d_addr : i_addr;
        in_range = (acc_addr < DEPTH64);
        idx      = acc_addr[AW-1:0];
        rd_word  = mem_rd[idx];
        wr_en    = gnt_d && d_we && in_range;
    end

    assign i_gnt = gnt_i;
    assign d_gnt = gnt_d;

    // Words carry their power-up contents and are never cleared by rst.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [63:0] word = INIT_IDENTITY ? 64'(g) : 64'd0;

        always_ff @(posedge clk) begin
            if (wr_en && (idx == AW'(g))) begin
                word <= d_wdata;
            end
        end

        assign mem_rd[g] = word;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid     <= 1'b0;
            i_rdata      <= '0;
            i_err        <= 1'b0;
            d_rvalid     <= 1'b0;
            d_rdata      <= '0;
            d_err        <= 1'b0;
            conflict_cnt <= '0;
            last_win     <= WIN_D;
        end else begin
            i_rvalid <= gnt_i;
            d_rvalid <= gnt_d;
            if (gnt_i) begin
                i_rdata <= in_range ? rd_word : 64'd0;
                i_err   <= !in_range;
            end
            // A write echoes its own data so the requester sees valM either way.
            if (gnt_d) begin
                d_rdata <= !in_range ? 64'd0 : (d_we ? d_wdata : rd_word);
                d_err   <= !in_range;
            end
            if (both_req) begin
                last_win <= gnt_i ? WIN_I : WIN_D;
                if (conflict_cnt != CNT_MAX) begin
                    conflict_cnt <= conflict_cnt + 1'b1;
                end
            end
        end
    end

endmodule
